// File: rtl/riscv_mon_pkg.sv
// Shared definitions for the RV32I commit-stream monitor: FSM encoding,
// the ECALL opcode and the width of one packed trace entry.
package riscv_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } mon_state_e;

    localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;

    // Packed entry layout is {pc, instr, result, we}.
    function automatic int trace_width(input int xlen);
        return 2 * xlen + 33;
    endfunction

endpackage

// File: rtl/riscv_commit_monitor_fifo.sv
// Pointer-plus-count trace FIFO. When full, a push is either dropped or
// overwrites the oldest entry; either way the loss is reported upward.
module trace_fifo #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 16,
    parameter int WRAP  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic             lost
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             pop;
    logic             write_en;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        pop      = pop_ready && !empty;
        write_en = push && (!full || pop || (WRAP != 0));
        lost     = push && full && !pop;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            last_d   = mem[rd_ptr_q];
        end
        if (write_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            // Overwrite: the oldest slot is reused, so the head moves past it.
            if (full && !pop) rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (write_en && !pop && !full) begin
            count_d = count_q + 1'b1;
        end else if (pop && !write_en) begin
            count_d = count_q - 1'b1;
        end

        // An empty FIFO keeps showing the most recently popped entry.
        head_data = empty ? last_q : mem[rd_ptr_q];
    end

    // NOTE: the storage array is not reset; count and pointers alone decide which slots are live.
    always_ff @(posedge clk) begin
        if (write_en) mem[wr_ptr_q] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: rtl/riscv_commit_monitor.sv
// Commit-stream monitor: run/halt FSM, saturating cycle and write-back
// counters, PC self-loop detector and a drainable trace of commits.
module riscv_commit_monitor
    import riscv_mon_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 16,
    parameter int HALT_CYCLES = 4,
    parameter int WRAP        = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [31:0]     commit_instr,
    input  logic [XLEN-1:0] commit_result,
    input  logic            commit_we,
    output logic            trace_valid,
    input  logic            trace_ready,
    output logic [XLEN-1:0] trace_pc,
    output logic [31:0]     trace_instr,
    output logic [XLEN-1:0] trace_result,
    output logic            trace_we,
    output logic [31:0]     cycle_count,
    output logic [31:0]     wb_count,
    output logic            halted,
    output logic            overflow,
    output logic [1:0]      state
);
    localparam int TW    = trace_width(XLEN);
    localparam int REP_W = $clog2(HALT_CYCLES + 1);

    mon_state_e      state_q, state_d;
    logic [31:0]     cycle_count_q, cycle_count_d;
    logic [31:0]     wb_count_q, wb_count_d;
    logic            halted_q, halted_d;
    logic            overflow_q, overflow_d;
    logic [XLEN-1:0] prev_pc_q, prev_pc_d;
    logic            prev_valid_q, prev_valid_d;
    logic [REP_W-1:0] repeat_q, repeat_d;
    logic            sample;
    logic            halt_hit;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_lost;
    logic [TW-1:0]   head_data;
    logic            unused_full;

    assign sample = (state_q == ST_RUN);

    trace_fifo #(
        .WIDTH (TW),
        .DEPTH (DEPTH),
        .WRAP  (WRAP)
    ) u_trace_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (sample),
        .push_data ({commit_pc, commit_instr, commit_result, commit_we}),
        .pop_ready (trace_ready),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .lost      (fifo_lost)
    );

    assign {trace_pc, trace_instr, trace_result, trace_we} = head_data;
    assign trace_valid = !fifo_empty;
    assign unused_full = fifo_full;

    always_comb begin
        state_d       = state_q;
        cycle_count_d = cycle_count_q;
        wb_count_d    = wb_count_q;
        halted_d      = halted_q;
        prev_pc_d     = prev_pc_q;
        prev_valid_d  = prev_valid_q;
        repeat_d      = repeat_q;
        halt_hit      = 1'b0;
        overflow_d    = overflow_q || fifo_lost;

        if (sample) begin
            if (cycle_count_q != '1) cycle_count_d = cycle_count_q + 1'b1;
            if (commit_we && (wb_count_q != '1)) wb_count_d = wb_count_q + 1'b1;
            prev_pc_d    = commit_pc;
            prev_valid_d = 1'b1;
            // The first sample after reset has no predecessor to compare against.
            repeat_d = (prev_valid_q && (commit_pc == prev_pc_q)) ? repeat_q + 1'b1 : '0;
            halt_hit = (commit_instr == INSTR_ECALL) || (repeat_d == REP_W'(HALT_CYCLES));
        end

        case (state_q)
            ST_IDLE: if (enable) state_d = ST_RUN;
            ST_RUN: begin
                if (halt_hit) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cycle_count_q <= '0;
            wb_count_q    <= '0;
            halted_q      <= 1'b0;
            overflow_q    <= 1'b0;
            prev_pc_q     <= '0;
            prev_valid_q  <= 1'b0;
            repeat_q      <= '0;
        end else begin
            state_q       <= state_d;
            cycle_count_q <= cycle_count_d;
            wb_count_q    <= wb_count_d;
            halted_q      <= halted_d;
            overflow_q    <= overflow_d;
            prev_pc_q     <= prev_pc_d;
            prev_valid_q  <= prev_valid_d;
            repeat_q      <= repeat_d;
        end
    end

    assign cycle_count = cycle_count_q;
    assign wb_count    = wb_count_q;
    assign halted      = halted_q;
    assign overflow    = overflow_q;
    assign state       = state_q;

endmodule
